mram_controller: RTL
====================

// Module: mram_controller
// PURPOSE
//  Sequences single-port asynchronous-read / clocked-write MRAM strobes from a valid/ready host port.
//  Sits between fabric logic and the MRAM array; one access in flight at a time.
//  Generates chip, output and write enables, byte lanes, address and write data, and returns read data/acks.
// PARAMETERS
//  ADDR_WIDTH   20  MRAM word address width
//  DATA_WIDTH   16  word width; two byte lanes, [7:0] lower, [15:8] upper
//  READ_WAIT     2  ACCESS cycles with e_n/g_n low before read data is captured (>=1)
//  WRITE_PULSE   1  ACCESS cycles with w_n low on a write (>=1)
// PORTS
//  clk            in   1           single clock, all logic rising-edge
//  rst            in   1           synchronous, active-high reset
//  req_valid      in   1           host request valid
//  req_ready      out  1           controller can accept; high only in IDLE
//  req_write      in   1           1 = write, 0 = read
//  req_addr       in   ADDR_WIDTH  word address
//  req_wdata      in   DATA_WIDTH  write data
//  req_be         in   2           byte enables, active-high, [0] lower, [1] upper
//  rsp_valid      out  1           1-cycle pulse: read data valid / write complete
//  rsp_rdata      out  DATA_WIDTH  read data; disabled lanes 0; all 0 on write ack
//  mram_e_n       out  1           chip enable, active-low
//  mram_g_n       out  1           output enable, active-low
//  mram_w_n       out  1           write enable, active-low
//  mram_lb_n      out  1           lower byte enable, active-low
//  mram_ub_n      out  1           upper byte enable, active-low
//  mram_address   out  ADDR_WIDTH  MRAM address
//  mram_dqi       out  DATA_WIDTH  MRAM write data
//  mram_dqo       in   DATA_WIDTH  MRAM read data (z on disabled lanes)
// BEHAVIOUR
//  - All outputs registered. Reset: all *_n = 1, mram_address = 0, mram_dqi = 0, rsp_valid = 0,
//    rsp_rdata = 0, req_ready = 0 while rst high; FSM -> IDLE; req_ready = 1 on the first cycle after.
//  - FSM: IDLE -> SETUP -> ACCESS (counter) -> HOLD -> IDLE.
//  - IDLE: req_ready = 1; accept on req_valid & req_ready; latch addr/wdata/be/write.
//  - SETUP (1 cycle): e_n = 0, lb_n/ub_n = ~be, address/dqi driven; w_n = 1; g_n = 0 for reads only.
//  - ACCESS write: w_n = 0, g_n = 1 for WRITE_PULSE cycles; address/dqi/lanes stable throughout.
//  - ACCESS read: e_n = g_n = 0, w_n = 1 for READ_WAIT cycles; mram_dqo is sampled at the last ACCESS edge.
//    Disabled lanes are forced to 0, never z or x.
//  - HOLD (1 cycle): all *_n = 1; rsp_valid = 1 with rsp_rdata. No w_n/g_n overlap ever.
//  - Latency: accept at cycle T; rsp_valid at T+2+READ_WAIT (read) or T+2+WRITE_PULSE (write).
//    Next accept no earlier than rsp_valid cycle + 1.
//  - req_be = 2'b00: accepted; no strobe asserted (e_n stays 1); rsp_valid in the same slot as a full
//    access, rsp_rdata = 0.
//  - req_valid while busy: ignored, not latched; host holds the request until req_ready.
//  - rst mid-operation: at the next edge all strobes deassert, FSM -> IDLE, pending rsp dropped
//    (no rsp_valid). A partially written word is undefined.
//  - Address passes through unmodified; no wrap logic.
// CONFIGURATION
//  MRAM_CTRL_STATS_EN defined:
//    - adds outputs stat_reads and stat_writes, 16 bits each.
//    - each increments on its rsp_valid, including be=00 requests; saturates at 16'hFFFF; cleared by rst.
//  MRAM_CTRL_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING (READ_WAIT = 2, WRITE_PULSE = 1)
//  1) Write addr 3, 0xA5C3, be = 11 -> w_n low 1 cycle; rsp_valid at T+3. Read addr 3 -> rsp_rdata 0xA5C3 at T+4.
//  2) Write addr 3, 0x00FF, be = 01 -> only lb_n low. Read addr 3, be = 11 -> 0xA5FF.
//  3) Read addr 3, be = 10 -> ub_n = 0, lb_n = 1; rsp_rdata 0xA500 (lower lane 0, not z).
//  4) Back-to-back: req_valid held high for 2 writes -> req_ready low SETUP..HOLD; second accepted the
//     cycle after the first rsp_valid; both words read back correctly.
//  5) rst asserted during write ACCESS -> next cycle all *_n = 1, no rsp_valid, req_ready = 1 after
//     rst drops; be = 00 request -> e_n never low, rsp_valid with 0.
//  6) STATS_EN: 3 writes + 2 reads -> stat_writes = 3, stat_reads = 2; preload 16'hFFFE, then 3 reads
//     -> stat_reads holds at 16'hFFFF.

Source files
------------

// File: rtl/mram_controller.sv
// mram_controller
// Sequences single-port MRAM strobes (asynchronous read, clocked write) from a
// valid/ready host port, one access in flight at a time.
// Access flow: IDLE -> SETUP -> ACCESS (READ_WAIT or WRITE_PULSE cycles) -> HOLD -> IDLE.
// Every output is registered; the *_d values describe the state being entered.
// Optional: define MRAM_CTRL_STATS_EN to add saturating 16-bit completion
// counters stat_reads / stat_writes.
module mram_controller #(
    parameter int ADDR_WIDTH  = 20,
    parameter int DATA_WIDTH  = 16,
    parameter int READ_WAIT   = 2,
    parameter int WRITE_PULSE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]            req_be,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  mram_e_n,
    output logic                  mram_g_n,
    output logic                  mram_w_n,
    output logic                  mram_lb_n,
    output logic                  mram_ub_n,
    output logic [ADDR_WIDTH-1:0] mram_address,
    output logic [DATA_WIDTH-1:0] mram_dqi,
    input  logic [DATA_WIDTH-1:0] mram_dqo
`ifdef MRAM_CTRL_STATS_EN
    ,
    output logic [15:0]           stat_reads,
    output logic [15:0]           stat_writes
`endif
);

    localparam int LANE_WIDTH = DATA_WIDTH / 2;
    localparam int MAX_LEN    = (READ_WAIT > WRITE_PULSE) ? READ_WAIT : WRITE_PULSE;
    localparam int CNT_WIDTH  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic [1:0]            be_q, be_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  e_n_q, e_n_d;
    logic                  g_n_q, g_n_d;
    logic                  w_n_q, w_n_d;
    logic                  lb_n_q, lb_n_d;
    logic                  ub_n_q, ub_n_d;

    logic                  accept;
    logic [CNT_WIDTH-1:0]  last_cnt;
    logic [DATA_WIDTH-1:0] lane_mask;

    assign accept    = req_valid & req_ready_q;
    assign last_cnt  = write_q ? CNT_WIDTH'(WRITE_PULSE - 1) : CNT_WIDTH'(READ_WAIT - 1);
    assign lane_mask = {{LANE_WIDTH{be_q[1]}}, {LANE_WIDTH{be_q[0]}}};

    // State register plus the captured request that is in flight.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            be_q    <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next state, ACCESS cycle counter and request capture on accept.
    always_comb begin
        // NOTE: every signal gets its held value first so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_SETUP;
                    write_d = req_write;
                    be_d    = req_be;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
                cnt_d   = '0;
            end
            S_ACCESS: begin
                if (cnt_q == last_cnt) begin
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            S_HOLD:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output values for the state being entered; w_n and g_n are never low together.
    always_comb begin
        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_HOLD);
        rsp_rdata_d = '0;
        e_n_d       = 1'b1;
        g_n_d       = 1'b1;
        w_n_d       = 1'b1;
        lb_n_d      = 1'b1;
        ub_n_d      = 1'b1;
        // A request with no byte lanes runs the full timeline without touching the array.
        if ((state_d == S_SETUP || state_d == S_ACCESS) && (be_d != 2'b00)) begin
            e_n_d  = 1'b0;
            lb_n_d = ~be_d[0];
            ub_n_d = ~be_d[1];
            if (write_d) begin
                w_n_d = (state_d != S_ACCESS);
            end else begin
                g_n_d = 1'b0;
            end
        end
        // Read data is captured on the edge that closes the last ACCESS cycle;
        // disabled lanes are forced to zero rather than passing a floating bus.
        if (state_q == S_ACCESS && state_d == S_HOLD && !write_q) begin
            rsp_rdata_d = mram_dqo & lane_mask;
        end
    end

    // Output registers; reset parks every strobe inactive and drops any pending response.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            e_n_q       <= 1'b1;
            g_n_q       <= 1'b1;
            w_n_q       <= 1'b1;
            lb_n_q      <= 1'b1;
            ub_n_q      <= 1'b1;
        end else begin
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            e_n_q       <= e_n_d;
            g_n_q       <= g_n_d;
            w_n_q       <= w_n_d;
            lb_n_q      <= lb_n_d;
            ub_n_q      <= ub_n_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign mram_e_n     = e_n_q;
    assign mram_g_n     = g_n_q;
    assign mram_w_n     = w_n_q;
    assign mram_lb_n    = lb_n_q;
    assign mram_ub_n    = ub_n_q;
    assign mram_address = addr_q;
    assign mram_dqi     = wdata_q;

`ifdef MRAM_CTRL_STATS_EN
    logic [15:0] stat_reads_q, stat_reads_d;
    logic [15:0] stat_writes_q, stat_writes_d;

    // Saturating completion counters, bumped on the edge that raises rsp_valid.
    always_comb begin
        stat_reads_d  = stat_reads_q;
        stat_writes_d = stat_writes_q;
        if (rsp_valid_d) begin
            if (write_q) begin
                if (stat_writes_q != 16'hFFFF) stat_writes_d = stat_writes_q + 16'd1;
            end else begin
                if (stat_reads_q != 16'hFFFF) stat_reads_d = stat_reads_q + 16'd1;
            end
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_reads_q  <= 16'd0;
            stat_writes_q <= 16'd0;
        end else begin
            stat_reads_q  <= stat_reads_d;
            stat_writes_q <= stat_writes_d;
        end
    end

    assign stat_reads  = stat_reads_q;
    assign stat_writes = stat_writes_q;
`endif

endmodule
